int_vector_ctrl: RTL and testbench

//  Interrupt/vector controller feeding the single-cycle core's PC-select stage.

---
 rtl/int_vector_ctrl.sv | 136 +++++++++++++
 tb/tb_int_vector_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_vector_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : int_vector_ctrl                                            |
// | Description : Interrupt/vector controller for the core's PC-select stage.|
// |               Edge-detects NUM_IRQ request lines into pending bits,      |
// |               masks them and dispatches the lowest index. Dispatch emits |
// |               a one-cycle INT with the vector, cause and saved return PC,|
// |               and further dispatch is blocked until eret.                |
// | Ports       : clk, reset      - clock, synchronous active-high reset     |
// |               irq             - request lines (rising edge = request)    |
// |               maskWe, maskIn  - mask load strobe and value               |
// |               eret, pcNow     - handler return pulse, return address     |
// |               INT, entryPoint - redirect pulse and target vector         |
// |               epc, cause      - saved return address, dispatched index   |
// |               inService       - handler active (INT cycle .. eret)       |
// |               pendingOut      - current pending bits                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module int_vector_ctrl #(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [31:0]        VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0]        VEC_STRIDE = 32'h0000_0010,
    parameter logic [NUM_IRQ-1:0] RESET_MASK = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               maskWe,
    input  logic [NUM_IRQ-1:0] maskIn,
    input  logic               eret,
    input  logic [31:0]        pcNow,
    output logic               INT,
    output logic [31:0]        entryPoint,
    output logic [31:0]        epc,
    output logic [2:0]         cause,
    output logic               inService,
    output logic [NUM_IRQ-1:0] pendingOut
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_fire    = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_int;
    logic               r_in_service;
    logic [31:0]        r_entry;
    logic [31:0]        r_epc;
    logic [2:0]         r_cause;

    logic [NUM_IRQ-1:0] w_req;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [2:0]         w_idx;
    logic               w_fire;
    logic [31:0]        w_vec;

    always_comb begin
        w_req  = r_pending & r_mask;
        w_set  = irq & ~r_irq_q;
        w_fire = (r_state == c_st_idle) && (|w_req);
        // Scan from the top down so the lowest set index is the last one written.
        w_idx  = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_idx = 3'(i);
            end
        end
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_fire && (w_idx == 3'(i));
        end
        // Product deliberately wraps at 32 bits.
        w_vec = VEC_BASE + (32'(w_idx) * VEC_STRIDE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            // All ones so a line already high when reset releases is not an edge.
            r_irq_q      <= '1;
            r_pending    <= '0;
            r_mask       <= RESET_MASK;
            r_int        <= 1'b0;
            r_in_service <= 1'b0;
            r_entry      <= '0;
            r_epc        <= '0;
            r_cause      <= '0;
        end else begin
            r_irq_q   <= irq;
            // A new edge on the bit being dispatched re-arms it (set wins).
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (maskWe) begin
                r_mask <= maskIn;
            end
            r_int <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_fire) begin
                        r_state      <= c_st_fire;
                        r_int        <= 1'b1;
                        r_in_service <= 1'b1;
                        r_cause      <= w_idx;
                        r_entry      <= w_vec;
                        r_epc        <= pcNow;
                    end
                end
                c_st_fire: begin
                    r_state <= c_st_service;
                end
                c_st_service: begin
                    if (eret) begin
                        r_state      <= c_st_idle;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= c_st_idle;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign INT        = r_int;
    assign entryPoint = r_entry;
    assign epc        = r_epc;
    assign cause      = r_cause;
    assign inService  = r_in_service;
    assign pendingOut = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_vector_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_int_vector_ctrl                                         |
// | Description : Scoreboard bench for int_vector_ctrl. Stimulus pushes the  |
// |               expected dispatch (cause, vector, epc, pending, cycle);    |
// |               a monitor pops and compares on every INT pulse.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_int_vector_ctrl;

    localparam int c_n = 4;

    typedef struct {
        logic [2:0]     cause;
        logic [31:0]    entry;
        logic [31:0]    epc;
        logic [c_n-1:0] pend;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [c_n-1:0] irq;
    logic           maskWe;
    logic [c_n-1:0] maskIn;
    logic           eret;
    logic [31:0]    pcNow;
    logic           INT;
    logic [31:0]    entryPoint;
    logic [31:0]    epc;
    logic [2:0]     cause;
    logic           inService;
    logic [c_n-1:0] pendingOut;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    int_vector_ctrl #(
        .NUM_IRQ    (c_n),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010),
        .RESET_MASK (4'b1111)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .maskWe     (maskWe),
        .maskIn     (maskIn),
        .eret       (eret),
        .pcNow      (pcNow),
        .INT        (INT),
        .entryPoint (entryPoint),
        .epc        (epc),
        .cause      (cause),
        .inService  (inService),
        .pendingOut (pendingOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_int(input logic [2:0] c, input logic [31:0] e,
                              input logic [31:0] pc, input logic [c_n-1:0] p, input int at);
        exp_t x;
        x.cause = c;
        x.entry = e;
        x.epc   = pc;
        x.pend  = p;
        x.cyc   = at;
        q_exp.push_back(x);
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    // Monitor: every INT pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (INT === 1'b1) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_int: got INT=1 cause=%0d expected no INT (cycle %0d)", cause, cyc);
            end else begin
                exp_t x;
                x = q_exp.pop_front();
                chk("int_cycle", 32'(cyc), 32'(x.cyc));
                chk("cause", 32'(cause), 32'(x.cause));
                chk("entryPoint", entryPoint, x.entry);
                chk("epc", epc, x.epc);
                chk("pending_at_int", 32'(pendingOut), 32'(x.pend));
                chk("inService_at_int", 32'(inService), 32'd1);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        irq    = 4'b0001;
        maskWe = 1'b0;
        maskIn = 4'b0000;
        eret   = 1'b0;
        pcNow  = 32'h0;

        // Reset with irq[0] held high: no trigger afterwards.
        tick(3);
        chk("rst_INT", 32'(INT), 32'd0);
        chk("rst_inService", 32'(inService), 32'd0);
        chk("rst_entryPoint", entryPoint, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_pending", 32'(pendingOut), 32'd0);
        reset = 1'b0;
        tick(4);
        chk("held_irq_pending", 32'(pendingOut), 32'd0);
        irq = 4'b0000;
        tick();

        // Single request on irq[2].
        irq   = 4'b0100;
        pcNow = 32'h40;
        expect_int(3'd2, 32'h120, 32'h40, 4'b0000, cyc + 2);
        tick(2);
        tick();
        chk("service_after_fire", 32'(inService), 32'd1);
        irq = 4'b0000;
        tick(2);
        pulse_eret();
        chk("inService_after_eret", 32'(inService), 32'd0);
        tick(2);

        // Simultaneous irq[1] and irq[3]: lowest first, the other after eret.
        irq   = 4'b1010;
        pcNow = 32'h44;
        expect_int(3'd1, 32'h110, 32'h44, 4'b1000, cyc + 2);
        tick(4);
        chk("held_pending_in_service", 32'(pendingOut), 32'b1000);
        pcNow = 32'h48;
        expect_int(3'd3, 32'h130, 32'h48, 4'b0000, cyc + 2);
        pulse_eret();
        tick(3);
        irq = 4'b0000;
        pulse_eret();
        tick(2);

        // Masked request stays pending, dispatches once unmasked.
        maskWe = 1'b1;
        maskIn = 4'b1110;
        tick();
        maskWe = 1'b0;
        irq    = 4'b0001;
        tick(4);
        chk("masked_pending", 32'(pendingOut), 32'b0001);
        chk("masked_no_service", 32'(inService), 32'd0);
        irq    = 4'b0000;
        pcNow  = 32'h50;
        maskWe = 1'b1;
        maskIn = 4'b1111;
        expect_int(3'd0, 32'h100, 32'h50, 4'b0000, cyc + 2);
        tick();
        maskWe = 1'b0;
        tick(3);
        pulse_eret();
        tick(2);

        // New edge during SERVICE waits for eret.
        irq   = 4'b0100;
        pcNow = 32'h60;
        expect_int(3'd2, 32'h120, 32'h60, 4'b0000, cyc + 2);
        tick(3);
        irq = 4'b0101;
        tick(3);
        chk("service_latched_pending", 32'(pendingOut), 32'b0001);
        pcNow = 32'h64;
        expect_int(3'd0, 32'h100, 32'h64, 4'b0000, cyc + 2);
        pulse_eret();
        tick(3);
        irq = 4'b0000;
        pulse_eret();
        tick(2);

        // Reset while in SERVICE with irq[2] pending.
        irq   = 4'b0001;
        pcNow = 32'h70;
        expect_int(3'd0, 32'h100, 32'h70, 4'b0000, cyc + 2);
        tick(3);
        irq = 4'b0101;
        tick();
        chk("pre_reset_pending", 32'(pendingOut), 32'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_inService", 32'(inService), 32'd0);
        chk("mid_reset_pending", 32'(pendingOut), 32'd0);
        chk("mid_reset_INT", 32'(INT), 32'd0);
        tick(6);
        chk("post_reset_pending", 32'(pendingOut), 32'd0);
        chk("post_reset_inService", 32'(inService), 32'd0);

        // Every queued dispatch must have been observed.
        begin
            int budget = 0;
            while (q_exp.size() != 0 && budget < 50) begin
                tick();
                budget++;
            end
        end
        chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
